// File: rtl/snd_pkg.sv
// snd_pkg: items shared by the 1-bit audio path (generators and decimator).
//   SND_POS      - snd bit level that means positive full scale.
//   clog2        - ceil(log2(v)) for elaborating widths.
//   CIC_L/CIC_W  - CIC bit growth L = ORDER*log2(DECIM) and register width
//                  W = L+1. The comb output can reach exactly 2^L, which needs
//                  the extra bit.
//   dec_state_e  - decimator warm-up / running state.
package snd_pkg;

  localparam logic SND_POS = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int CIC_L(input int decim, input int order);
    return order * clog2(decim);
  endfunction

  function automatic int CIC_W(input int decim, input int order);
    return CIC_L(decim, order) + 1;
  endfunction

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } dec_state_e;

endpackage

// File: rtl/snd_sat_trunc.sv
// snd_sat_trunc: converts a W-bit unsigned CIC comb result c in [0, 2^L] into
// an OUT_BITS signed PCM sample: s = (c >> (L-OUT_BITS)) - 2^(OUT_BITS-1).
// The single value that lands on +2^(OUT_BITS-1) is saturated to the largest
// positive code and flagged with o_clip. Purely combinational.
// Ports:
//   i_comb    in   W         comb chain output (unsigned)
//   o_sample  out  OUT_BITS  signed PCM sample
//   o_clip    out  1         sample was saturated to +max
module snd_sat_trunc
  import snd_pkg::*;
#(
  parameter int L        = 18,
  parameter int W        = 19,
  parameter int OUT_BITS = 16
) (
  input  logic [W-1:0]               i_comb,
  output logic signed [OUT_BITS-1:0] o_sample,
  output logic                       o_clip
);

  localparam int SH = L - OUT_BITS;

  // After the shift the value fits in OUT_BITS+1 bits and lies in
  // [0, 2^OUT_BITS]; the top bit is set only for the full-scale value.
  logic [OUT_BITS:0] w_top;
  assign w_top = i_comb[W-1:SH];

  if (SH > 0) begin : g_drop
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^i_comb[SH-1:0];
  end

  // Subtracting 2^(OUT_BITS-1) from an OUT_BITS-bit value is an MSB flip.
  always_comb begin
    o_clip = w_top[OUT_BITS];
    if (w_top[OUT_BITS]) begin
      o_sample = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else begin
      o_sample = {~w_top[OUT_BITS-1], w_top[OUT_BITS-2:0]};
    end
  end

endmodule

// File: rtl/snd_pdm_decim.sv
// snd_pdm_decim: CIC decimator turning the 1-bit snd density stream into
// signed PCM samples at clk/DECIM.
// Ports:
//   clk           in   1         system clock, one snd bit sampled per cycle
//   reset         in   1         synchronous, active-high
//   snd_in        in   1         1-bit audio stream (SND_POS = +full scale)
//   sample        out  OUT_BITS  signed PCM sample, held between strobes
//   sample_valid  out  1         one-cycle strobe: sample updated this cycle
//   clip          out  1         sample saturated to +max; updates with sample
//   dbg_state     out  1         warm-up / running state of the output gate
//
// Handshake: sample_valid is a pure strobe with no ready; sample and clip
// change only in a cycle where sample_valid is 1 and hold otherwise.
//
// Timing: edge E0 samples the last bit of a window (cnt = DECIM-1).
// E0+1 runs the comb chain on the decimated integrator value and registers
// the comb result; E0+2 registers sample/clip and pulses sample_valid.
module snd_pdm_decim
  import snd_pkg::*;
#(
  parameter int DECIM    = 64,
  parameter int ORDER    = 3,
  parameter int OUT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       snd_in,
  output logic signed [OUT_BITS-1:0] sample,
  output logic                       sample_valid,
  output logic                       clip,
  output dec_state_e                 dbg_state
);

  localparam int L  = CIC_L(DECIM, ORDER);
  localparam int W  = CIC_W(DECIM, ORDER);
  localparam int CW = clog2(DECIM);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DECIM - 1);
  localparam logic [2:0]    WARM_LAST = 3'(ORDER - 1);

  logic [CW-1:0]              r_cnt;
  logic                       r_dec_stb;
  logic                       r_comb_stb;
  logic [W-1:0]               r_comb_out;
  logic [2:0]                 r_warm;
  dec_state_e                 r_state;
  dec_state_e                 w_state_nxt;
  logic                       w_warm_inc;
  logic                       w_emit;
  logic                       w_bit;
  logic [W-1:0]               w_dec_x;
  logic [W-1:0]               w_comb_last;
  logic signed [OUT_BITS-1:0] w_sat_sample;
  logic                       w_sat_clip;

  assign w_bit = (snd_in == SND_POS);

  // Integrator chain: free-running, wraps modulo 2^W by design.
  for (genvar k = 0; k < ORDER; k++) begin : g_int
    logic [W-1:0] w_add;
    logic [W-1:0] r_acc;
    if (k == 0) begin : g_src
      assign w_add = {{(W-1){1'b0}}, w_bit};
    end else begin : g_src
      assign w_add = g_int[k-1].r_acc;
    end
    always_ff @(posedge clk) begin
      if (reset) r_acc <= '0;
      else       r_acc <= r_acc + w_add;
    end
  end

  assign w_dec_x = g_int[ORDER-1].r_acc;

  // Comb chain: combinational differences against the previous decimated
  // input of each stage; history advances once per window, warm-up included.
  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic [W-1:0] r_prev;
    if (k == 0) begin : g_src
      assign w_x = w_dec_x;
    end else begin : g_src
      assign w_x = g_comb[k-1].w_y;
    end
    assign w_y = w_x - r_prev;
    always_ff @(posedge clk) begin
      if (reset)          r_prev <= '0;
      else if (r_dec_stb) r_prev <= w_x;
    end
  end

  assign w_comb_last = g_comb[ORDER-1].w_y;

  // Output gate: the first ORDER decimated results only prime the combs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WARM;
      r_warm  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_warm_inc) r_warm <= r_warm + 3'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_warm_inc  = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_WARM: begin
        if (r_dec_stb) begin
          w_warm_inc = 1'b1;
          if (r_warm == WARM_LAST) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_emit = r_dec_stb;
      end
    endcase
  end

  assign dbg_state = r_state;

  snd_sat_trunc #(
    .L        (L),
    .W        (W),
    .OUT_BITS (OUT_BITS)
  ) u_sat (
    .i_comb   (r_comb_out),
    .o_sample (w_sat_sample),
    .o_clip   (w_sat_clip)
  );

  // Window counter, decimation strobe and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_dec_stb    <= 1'b0;
      r_comb_stb   <= 1'b0;
      r_comb_out   <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + CW'(1);
      r_dec_stb    <= (r_cnt == CNT_LAST);
      r_comb_stb   <= w_emit;
      if (w_emit) r_comb_out <= w_comb_last;
      sample_valid <= r_comb_stb;
      if (r_comb_stb) begin
        sample <= w_sat_sample;
        clip   <= w_sat_clip;
      end
    end
  end

endmodule

// File: tb/tb_snd_pdm_decim.sv
module tb_snd_pdm_decim;
  import snd_pkg::*;

  localparam int DECIM    = 64;
  localparam int ORDER    = 3;
  localparam int OUT_BITS = 16;
  localparam int EW       = OUT_BITS + 2;  // {care, clip, sample}

  localparam int K_ZERO = 0;
  localparam int K_ONE  = 1;
  localparam int K_ALT  = 2;
  localparam int K_1000 = 3;
  localparam int K_1110 = 4;
  localparam int K_RND  = 5;

  // ---------------- clock / reset ----------------
  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       snd_in = 1'b0;
  logic signed [OUT_BITS-1:0] sample;
  logic                       sample_valid;
  logic                       clip;
  dec_state_e                 dbg_state;

  always #5 clk = ~clk;

  snd_pdm_decim #(
    .DECIM    (DECIM),
    .ORDER    (ORDER),
    .OUT_BITS (OUT_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .snd_in       (snd_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .clip         (clip),
    .dbg_state    (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;
  int last_strobe = -1;
  logic [3:0]    rnd_pat = 4'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  always @(posedge clk) edge_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    #1;
    if (reset) begin
      last_strobe = -1;
    end else if (sample_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: edge %0d sample=%0d, required no strobe", edge_cnt, sample);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[EW-1]) begin
          vectors++;
          if (sample !== mon_e[OUT_BITS-1:0] || clip !== mon_e[OUT_BITS]) begin
            miscompares++;
            $display("FAIL sample_value: edge %0d got sample=%0d clip=%0b, required sample=%0d clip=%0b",
                     edge_cnt, sample, clip, $signed(mon_e[OUT_BITS-1:0]), mon_e[OUT_BITS]);
          end
        end
      end
      if (last_strobe >= 0) begin
        vectors++;
        if (edge_cnt - last_strobe != DECIM) begin
          miscompares++;
          $display("FAIL strobe_interval: got %0d edges, required %0d", edge_cnt - last_strobe, DECIM);
        end
      end
      last_strobe = edge_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    @(negedge clk);
    snd_in = b;
    @(posedge clk);
  endtask

  function automatic logic pat_bit(input int kind, input int i);
    case (kind)
      K_ZERO:  return 1'b0;
      K_ONE:   return 1'b1;
      K_ALT:   return (i % 2) == 0;
      K_1000:  return (i % 4) == 0;
      K_1110:  return (i % 4) != 3;
      default: return rnd_pat[i % 4];
    endcase
  endfunction

  // n windows of a pattern; the first n_warm push nothing (no strobe allowed),
  // the next n_dc push don't-care entries (settling after a change).
  task automatic run_windows(input int n, input int kind, input int n_warm, input int n_dc,
                             input logic signed [OUT_BITS-1:0] exp_s, input logic exp_clip);
    for (int w = 0; w < n; w++) begin
      if (w >= n_warm) exp_q.push_back({(w >= n_warm + n_dc), exp_clip, exp_s});
      for (int i = 0; i < DECIM; i++) drive_bit(pat_bit(kind, i));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      snd_in = ~snd_in;
      @(posedge clk);
      #1;
      vectors++;
      if (sample !== 16'sd0 || sample_valid !== 1'b0 || clip !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: sample=%0d valid=%0b clip=%0b, required 0/0/0",
                 sample, sample_valid, clip);
      end
    end
    vectors++;
    if (dbg_state !== ST_WARM) begin
      miscompares++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_WARM);
    end
    // Released between edges: the next edge samples bit 0 of window 0.
    reset = 1'b0;
  endtask

  task automatic test_all_ones;
    run_windows(6, K_ONE, ORDER, 0, 16'sd32767, 1'b1);
    vectors++;
    if (dbg_state !== ST_RUN) begin
      miscompares++;
      $display("FAIL run_state: got %0d, required %0d", dbg_state, ST_RUN);
    end
  endtask

  task automatic test_all_zeros;
    run_windows(6, K_ZERO, 0, ORDER, -16'sd32768, 1'b0);
  endtask

  task automatic test_patterns;
    run_windows(5, K_ALT,  0, ORDER, 16'sd0,      1'b0);
    run_windows(5, K_1000, 0, ORDER, -16'sd16384, 1'b0);
    run_windows(5, K_1110, 0, ORDER, 16'sd16384,  1'b0);
  endtask

  // Period-4 patterns: density = ones/4, so sample = ones*16384 - 32768.
  task automatic test_random_periodic;
    int ones;
    int v;
    for (int r = 0; r < 3; r++) begin
      rnd_pat = 4'($urandom_range(0, 15));
      ones = $countones(rnd_pat);
      v = ones * 16384 - 32768;
      if (ones == 4) run_windows(5, K_RND, 0, ORDER, 16'sd32767, 1'b1);
      else           run_windows(5, K_RND, 0, ORDER, 16'(v), 1'b0);
    end
  endtask

  task automatic test_latency;
    logic signed [OUT_BITS-1:0] s [3];
    run_windows(4, K_ZERO, 0, ORDER, -16'sd32768, 1'b0);
    for (int w = 0; w < 3; w++) begin
      exp_q.push_back({(w == 2), 1'b1, 16'sd32767});
      for (int i = (w == 0) ? 0 : 2; i < DECIM; i++) drive_bit(1'b1);
      drive_bit(1'b1);
      #1;
      vectors++;
      if (sample_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early: window %0d valid=%0b one edge after last bit, required 0", w, sample_valid);
      end
      drive_bit(1'b1);
      #1;
      vectors++;
      if (sample_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL latency_strobe: window %0d valid=%0b two edges after last bit, required 1", w, sample_valid);
      end
      s[w] = sample;
    end
    exp_q.push_back({1'b1, 1'b1, 16'sd32767});
    for (int i = 2; i < DECIM; i++) drive_bit(1'b1);
    vectors++;
    if (!(s[0] < s[1] && s[1] <= s[2] && s[2] == 16'sd32767)) begin
      miscompares++;
      $display("FAIL step_settle: got %0d,%0d,%0d, required rising to 32767", s[0], s[1], s[2]);
    end
  endtask

  task automatic test_reset_mid;
    int found;
    // Let the strobe of the last window queued by the previous test come out.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    snd_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_windows(5, K_ONE, ORDER, 0, 16'sd32767, 1'b1);
    for (int i = 0; i < 30; i++) drive_bit(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (sample !== 16'sd0 || sample_valid !== 1'b0 || clip !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_outputs: sample=%0d valid=%0b clip=%0b, required 0/0/0",
                 sample, sample_valid, clip);
      end
    end
    reset = 1'b0;
    exp_q.push_back({1'b1, 1'b1, 16'sd32767});
    found = 0;
    for (int k = 1; k <= 300 && found == 0; k++) begin
      drive_bit(1'b1);
      #1;
      if (sample_valid === 1'b1) found = k;
    end
    vectors++;
    if (found != 4 * DECIM + 2) begin
      miscompares++;
      $display("FAIL midreset_first_strobe: got edge %0d after release, required %0d", found, 4 * DECIM + 2);
    end
    exp_q.push_back({1'b1, 1'b1, 16'sd32767});
    for (int i = 2; i < DECIM; i++) drive_bit(1'b1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_end;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_strobes: %0d expected samples never produced, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_patterns();
    test_random_periodic();
    test_latency();
    test_reset_mid();
    test_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
